// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - memory handshake, hazard inputs and stage-control outputs of the pipeline controller
interface pipeline_ctrl_if;
    logic       imem_resp;
    logic       dmem_req;
    logic       dmem_resp;
    logic [2:0] id_sr1;
    logic [2:0] id_sr2;
    logic       id_sr1_used;
    logic       id_sr2_used;
    logic [2:0] ex_dr;
    logic       ex_is_load;
    logic       br_taken;

    logic       imem_read;
    logic       load_pc;
    logic       load_if_id;
    logic       load_id_ex;
    logic       load_ex_mem;
    logic       load_mem_wb;
    logic       bubble_id_ex;
    logic       flush_if_id;
    logic       flush_id_ex;
    logic       flush_ex_mem;

    modport master (
        output imem_resp, dmem_req, dmem_resp, id_sr1, id_sr2, id_sr1_used, id_sr2_used,
               ex_dr, ex_is_load, br_taken,
        input  imem_read, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               bubble_id_ex, flush_if_id, flush_id_ex, flush_ex_mem
    );

    modport slave (
        input  imem_resp, dmem_req, dmem_resp, id_sr1, id_sr2, id_sr1_used, id_sr2_used,
               ex_dr, ex_is_load, br_taken,
        output imem_read, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
               bubble_id_ex, flush_if_id, flush_id_ex, flush_ex_mem
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage pipeline controller: memory-wait FSM, load-use bubble, branch flush, stall counter
module pipeline_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    pipeline_ctrl_if.slave     ctrl,
    output logic [CNT_W-1:0]   o_stall_count,
    output logic [1:0]         o_state
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_stall_count;
    logic               w_imem_done;
    logic               w_dmem_done;
    logic               w_adv;
    logic               w_hazard;
    logic               w_bubble;
    logic               w_stall;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= RUN;
            r_stall_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_stall && (r_stall_count != {CNT_W{1'b1}}))
                r_stall_count <= r_stall_count + 1'b1;
        end
    end

    // A HOLD state remembers which memory already answered, so its response line is ignored there.
    always_comb begin
        w_imem_done  = ctrl.imem_resp || (r_state == HOLD_I);
        w_dmem_done  = !ctrl.dmem_req || ctrl.dmem_resp || (r_state == HOLD_D);
        w_adv        = i_rst_n && w_imem_done && w_dmem_done;
        w_hazard     = ctrl.ex_is_load &&
                       ((ctrl.id_sr1_used && (ctrl.id_sr1 == ctrl.ex_dr)) ||
                        (ctrl.id_sr2_used && (ctrl.id_sr2 == ctrl.ex_dr)));
        w_bubble     = w_adv && !ctrl.br_taken && w_hazard;
        w_stall      = !w_adv || w_bubble;

        w_next_state = RUN;
        case (r_state)
            RUN: begin
                if (!w_adv && ctrl.imem_resp)
                    w_next_state = HOLD_I;
                else if (!w_adv && ctrl.dmem_req && ctrl.dmem_resp)
                    w_next_state = HOLD_D;
            end
            HOLD_I:  w_next_state = w_adv ? RUN : HOLD_I;
            HOLD_D:  w_next_state = w_adv ? RUN : HOLD_D;
            default: w_next_state = RUN;
        endcase

        ctrl.imem_read    = i_rst_n && (r_state != HOLD_I);
        ctrl.load_pc      = w_adv && !w_bubble;
        ctrl.load_if_id   = w_adv && !w_bubble;
        ctrl.load_id_ex   = w_adv;
        ctrl.load_ex_mem  = w_adv;
        ctrl.load_mem_wb  = w_adv;
        ctrl.bubble_id_ex = w_bubble;
        ctrl.flush_if_id  = w_adv && ctrl.br_taken;
        ctrl.flush_id_ex  = w_adv && ctrl.br_taken;
        ctrl.flush_ex_mem = w_adv && ctrl.br_taken;
    end

    assign o_state       = i_rst_n ? r_state : 2'd0;
    assign o_stall_count = i_rst_n ? r_stall_count : '0;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed and randomized check of pipeline_ctrl against a completion-flag reference model
module tb_pipeline_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst4_n;
    logic [15:0] stall_count;
    logic [1:0]  state;
    logic [3:0]  stall4;
    logic [1:0]  state4;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: sticky "already answered" flags per memory, cleared when the pipe advances.
    bit got_i = 0;
    bit got_d = 0;
    int m_cnt = 0;

    pipeline_ctrl_if bus ();
    pipeline_ctrl_if bus4 ();

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(16)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .ctrl          (bus.slave),
        .o_stall_count (stall_count),
        .o_state       (state)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .i_clk         (clk),
        .i_rst_n       (rst4_n),
        .ctrl          (bus4.slave),
        .o_stall_count (stall4),
        .o_state       (state4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic bit m_hazard();
        return bus.ex_is_load &&
               ((bus.id_sr1_used && bus.id_sr1 == bus.ex_dr) ||
                (bus.id_sr2_used && bus.id_sr2 == bus.ex_dr));
    endfunction

    function automatic bit m_adv();
        bit idone, ddone;
        idone = bus.imem_resp || got_i;
        ddone = !bus.dmem_req || bus.dmem_resp || got_d;
        return rst_n && idone && ddone;
    endfunction

    // {imem_read, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, bubble, flush x3}
    function automatic logic [9:0] m_outs();
        logic [9:0] v;
        v = '0;
        v[9] = rst_n && !got_i;
        if (m_adv()) begin
            if (bus.br_taken)     v[8:0] = 9'b11111_0_111;
            else if (m_hazard())  v[8:0] = 9'b00111_1_000;
            else                  v[8:0] = 9'b11111_0_000;
        end
        return v;
    endfunction

    function automatic logic [9:0] dut_outs();
        return {bus.imem_read, bus.load_pc, bus.load_if_id, bus.load_id_ex, bus.load_ex_mem,
                bus.load_mem_wb, bus.bubble_id_ex, bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem};
    endfunction

    task automatic step(input string tag);
        bit adv, stall;
        #1;
        check({tag, "_outs"},  32'(dut_outs()), 32'(m_outs()));
        check({tag, "_state"}, 32'(state), rst_n ? (got_i ? 32'd1 : (got_d ? 32'd2 : 32'd0)) : 32'd0);
        check({tag, "_cnt"},   32'(stall_count), rst_n ? 32'(m_cnt) : 32'd0);
        @(posedge clk);
        adv   = m_adv();
        stall = !adv || (!bus.br_taken && m_hazard());
        if (!rst_n) begin
            got_i = 0; got_d = 0; m_cnt = 0;
        end else begin
            if (stall && m_cnt < 65535) m_cnt++;
            if (adv) begin
                got_i = 0; got_d = 0;
            end else begin
                got_i = got_i || bus.imem_resp;
                got_d = got_d || (bus.dmem_req && bus.dmem_resp);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.imem_resp = 0; bus.dmem_req = 0; bus.dmem_resp = 0;
        bus.id_sr1 = 0; bus.id_sr2 = 0; bus.id_sr1_used = 0; bus.id_sr2_used = 0;
        bus.ex_dr = 0; bus.ex_is_load = 0; bus.br_taken = 0;
    endtask

    initial begin
        rst_n = 0; rst4_n = 0;
        idle_inputs();
        bus4.imem_resp = 0; bus4.dmem_req = 0; bus4.dmem_resp = 0;
        bus4.id_sr1 = 0; bus4.id_sr2 = 0; bus4.id_sr1_used = 0; bus4.id_sr2_used = 0;
        bus4.ex_dr = 0; bus4.ex_is_load = 0; bus4.br_taken = 0;
        @(negedge clk);
        bus.imem_resp = 1;
        step("reset");
        check("reset_imem_read", 32'(bus.imem_read), 32'd0);

        // Narrow counter: 20 fetch-wait cycles must saturate at 15.
        rst4_n = 1;
        repeat (20) step("rst_hold");
        #1 check("sat4_cnt", 32'(stall4), 32'd15);
        check("sat4_state", 32'(state4), 32'd0);

        rst_n = 1;
        idle_inputs();
        bus.imem_resp = 1;
        step("run_adv");
        check("run_loads", 32'(dut_outs()), 32'b1_11111_0_000);

        bus.dmem_req = 1;
        step("d1_iresp");
        bus.imem_resp = 0;
        #1 check("d1_hold_i", 32'(state), 32'd1);
        check("d1_imem_read", 32'(bus.imem_read), 32'd0);
        step("d2_wait");
        bus.dmem_resp = 1;
        step("d3_dresp");
        #1 check("d3_cnt", 32'(stall_count), 32'd2);
        check("d3_state", 32'(state), 32'd0);

        idle_inputs();
        bus.imem_resp = 1; bus.ex_is_load = 1; bus.ex_dr = 3; bus.id_sr2 = 3; bus.id_sr2_used = 1;
        #1 check("haz_outs", 32'(dut_outs()), 32'b1_00111_1_000);
        step("hazard");
        #1 check("haz_cnt", 32'(stall_count), 32'd3);
        bus.br_taken = 1;
        #1 check("br_outs", 32'(dut_outs()), 32'b1_11111_0_111);
        step("br_haz");

        idle_inputs();
        bus.dmem_req = 1; bus.dmem_resp = 1;
        step("to_hold_d");
        #1 check("hold_d_state", 32'(state), 32'd2);
        rst_n = 0; bus.imem_resp = 1; bus.dmem_resp = 0;
        step("rst_in_hold_d");
        rst_n = 1; bus.imem_resp = 0;
        step("after_rst");

        for (int i = 0; i < 2000; i++) begin
            rst_n            = ($urandom_range(0, 40) != 0);
            bus.imem_resp    = $urandom_range(0, 1);
            bus.dmem_req     = $urandom_range(0, 1);
            bus.dmem_resp    = $urandom_range(0, 1);
            bus.id_sr1       = 3'($urandom_range(0, 3));
            bus.id_sr2       = 3'($urandom_range(0, 3));
            bus.id_sr1_used  = $urandom_range(0, 1);
            bus.id_sr2_used  = $urandom_range(0, 1);
            bus.ex_dr        = 3'($urandom_range(0, 3));
            bus.ex_is_load   = $urandom_range(0, 1);
            bus.br_taken     = ($urandom_range(0, 3) == 0);
            step("rand");
        end

        #1 check("sat4_end", 32'(stall4), 32'd15);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of stall_count.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 imem_resp  in  1  instruction memory read complete this cycle.
REQ-005 dmem_req  in  1  MEM-stage instruction needs data memory.
REQ-006 dmem_resp  in  1  data memory access complete this cycle.
REQ-007 id_sr1, id_sr2  in  3 each  ID-stage source registers.
REQ-008 id_sr1_used, id_sr2_used  in  1 each  source actually read.
REQ-009 ex_dr  in  3  destination of instruction in ID/EX.
REQ-010 ex_is_load  in  1  ID/EX instruction is a load (LDR/LDB/LDI).
REQ-011 br_taken  in  1  MEM-stage control transfer resolved taken.
REQ-012 imem_read  out  1  instruction fetch request.
REQ-013 load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  register load enables.
REQ-014 bubble_id_ex  out  1  load NOP into ID/EX instead of decoded instruction.
REQ-015 flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  clear stage to NOP on load.
REQ-016 stall_count  out  CNT_W  stall cycles since reset.
REQ-017 state  out  2  FSM state: RUN=0, HOLD_I=1, HOLD_D=2.

Function
REQ-018 imem_done = imem_resp or state==HOLD_I; dmem_done = !dmem_req or dmem_resp or state==HOLD_D.
REQ-019 adv = imem_done and dmem_done, combinational same cycle.
REQ-020 RUN: imem_done only -> HOLD_I; dmem_req and dmem_resp only -> HOLD_D; adv or neither -> RUN.
REQ-021 HOLD_I: imem_resp ignored; dmem_resp -> RUN with adv=1.
REQ-022 HOLD_D: dmem_resp ignored; imem_resp -> RUN with adv=1.
REQ-023 imem_read = rst_n and state!=HOLD_I.
REQ-024 adv=0: all load_*, flush_*, bubble_id_ex = 0.
REQ-025 hazard = ex_is_load and ((id_sr1_used and id_sr1==ex_dr) or (id_sr2_used and id_sr2==ex_dr)).
REQ-026 adv=1, br_taken=1: all five load_* =1; flush_if_id, flush_id_ex, flush_ex_mem =1; bubble_id_ex=0; hazard ignored.
REQ-027 adv=1, br_taken=0, hazard=1: load_pc=load_if_id=0; load_id_ex=load_ex_mem=load_mem_wb=1; bubble_id_ex=1; flushes 0.
REQ-028 adv=1, br_taken=0, hazard=0: all load_*=1; flushes and bubble 0.
REQ-029 stall_count +1 on each cycle with adv=0 or REQ-027 bubble; saturates at 2^CNT_W-1, no wrap.
REQ-030 Outputs combinational from state and inputs; only state and stall_count registered.

Reset
REQ-031 rst_n=0 at edge: state<=RUN, stall_count<=0, regardless of pending wait.
REQ-032 While rst_n=0: all outputs 0, imem_read=0, state=0.
REQ-033 First cycle after release: imem_read=1, state=RUN; earlier responses forgotten.

Verification
REQ-034 RUN, imem_resp=1, dmem_req=0, no hazard -> all load_*=1, state stays RUN, stall_count 0.
REQ-035 dmem_req=1: cycle1 imem_resp=1 -> loads 0, HOLD_I, imem_read=0; cycle3 dmem_resp=1 -> all loads 1, RUN, stall_count=2.
REQ-036 imem_resp=1, ex_is_load=1, ex_dr=3, id_sr2=3, id_sr2_used=1 -> load_pc=load_if_id=0, bubble_id_ex=1, stall_count+1.
REQ-037 Same hazard plus br_taken=1 -> all loads 1, three flushes 1, bubble_id_ex=0.
REQ-038 In HOLD_D, rst_n=0 one cycle -> outputs 0; after release state=RUN, stall_count=0; stale imem_resp not counted.
REQ-039 CNT_W=4, hold imem_resp=0 20 cycles -> stall_count 15 and stays 15.
